// File: rtl/alu_pkg.sv
// Shared constants and types for the RV32I ALU issue stage: ALU op codes,
// opcode/funct3 encodings, the buffered entry layout and skid-buffer states.
package alu_pkg;

  localparam int XLEN = 32;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0100;
  localparam logic [3:0] ALU_XOR = 4'b0101;
  localparam logic [3:0] ALU_SRL = 4'b1000;
  localparam logic [3:0] ALU_SLL = 4'b1001;
  localparam logic [3:0] ALU_SRA = 4'b1010;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;

  typedef struct packed {
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [3:0]      alu_op;
    logic [4:0]      rd;
    logic            rd_we;
    logic            illegal;
  } issue_entry_t;

  localparam issue_entry_t ENTRY_IDLE = '{
    op1: '0, op2: '0, alu_op: ALU_ADD, rd: '0, rd_we: 1'b0, illegal: 1'b0
  };

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_e;

  // Shared R-type / I-ALU funct3 map; allow_sub is clear for immediates (no SUBI).
  function automatic logic [3:0] alu_op_from_funct3(input logic [2:0] funct3,
                                                    input logic       alt,
                                                    input logic       allow_sub);
    logic [3:0] op;
    op = ALU_ADD;
    case (funct3)
      F3_ADD:  op = (alt && allow_sub) ? ALU_SUB : ALU_ADD;
      F3_SLL:  op = ALU_SLL;
      F3_SLT:  op = ALU_SLT;
      F3_XOR:  op = ALU_XOR;
      F3_SR:   op = alt ? ALU_SRA : ALU_SRL;
      F3_OR:   op = ALU_OR;
      F3_AND:  op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_issue_stage_if.sv
// Upstream instruction handshake plus downstream ALU-operand handshake of the
// issue stage. The stage itself uses the slave view; its driver the master view.
interface alu_issue_stage_if;
  import alu_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] instr;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;

  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;
  logic [3:0]      alu_op;
  logic [4:0]      rd;
  logic            rd_we;
  logic            illegal;

  modport master (
    output in_valid, instr, rs1_data, rs2_data, out_ready,
    input  in_ready, out_valid, op1, op2, alu_op, rd, rd_we, illegal
  );

  modport slave (
    input  in_valid, instr, rs1_data, rs2_data, out_ready,
    output in_ready, out_valid, op1, op2, alu_op, rd, rd_we, illegal
  );

endinterface

// File: rtl/alu_issue_decode.sv
// Combinational RV32I decode: picks ALU operands and op code for one
// instruction and flags anything this stage cannot issue.
module alu_issue_decode
  import alu_pkg::*;
(
  input  logic [XLEN-1:0] instr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic [XLEN-1:0] op1,
  output logic [XLEN-1:0] op2,
  output logic [3:0]      alu_op,
  output logic [4:0]      rd,
  output logic            rd_we,
  output logic            illegal
);

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] shamt;
  logic [XLEN-1:0] dec_op2;
  logic [3:0]      dec_alu_op;
  logic            dec_we;
  logic            dec_bad;

  // Register indices are resolved before this stage; only the read values matter.
  logic unused_rs1_idx;
  assign unused_rs1_idx = ^instr[19:15];

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign shamt  = {27'b0, instr[24:20]};

  always_comb begin
    dec_op2    = '0;
    dec_alu_op = ALU_ADD;
    dec_we     = 1'b0;
    dec_bad    = 1'b0;
    case (opcode)
      OPC_OP: begin
        dec_op2    = rs2_data;
        dec_we     = 1'b1;
        dec_alu_op = alu_op_from_funct3(funct3, instr[30], 1'b1);
        if (funct3 == F3_SLTU || (funct7 != 7'b0000000 && funct7 != 7'b0100000)) begin
          dec_bad = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        dec_we     = 1'b1;
        dec_alu_op = alu_op_from_funct3(funct3, instr[30], 1'b0);
        dec_op2    = (funct3 == F3_SLL || funct3 == F3_SR) ? shamt : imm_i;
        dec_bad    = (funct3 == F3_SLTU);
      end
      OPC_LOAD: begin
        dec_op2 = imm_i;
        dec_we  = 1'b1;
      end
      OPC_STORE: begin
        dec_op2 = imm_s;
      end
      OPC_BRANCH: begin
        dec_op2 = rs2_data;
        case (funct3)
          F3_BEQ, F3_BNE: dec_alu_op = ALU_SUB;
          F3_BLT, F3_BGE: dec_alu_op = ALU_SLT;
          default:        dec_bad    = 1'b1;
        endcase
      end
      default: dec_bad = 1'b1;
    endcase
  end

  // Illegal entries travel as inert ADD 0,0 so the ALU never sees stray operands.
  assign op1     = dec_bad ? '0 : rs1_data;
  assign op2     = dec_bad ? '0 : dec_op2;
  assign alu_op  = dec_bad ? ALU_ADD : dec_alu_op;
  assign rd      = instr[11:7];
  assign rd_we   = dec_we && !dec_bad && (instr[11:7] != 5'd0);
  assign illegal = dec_bad;

endmodule

// File: rtl/alu_issue_stage.sv
// Issue stage in front of the ALU: decode feeding a registered 2-entry skid
// buffer (main + skid) with valid/ready on both sides and a registered in_ready.
module alu_issue_stage #(
  parameter int XLEN  = alu_pkg::XLEN,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  alu_issue_stage_if.slave bus
);

  localparam int MAIN = 0;
  localparam int SKID = 1;

  alu_pkg::skid_state_e  state_q, state_d;
  logic                  in_ready_q, in_ready_d;
  alu_pkg::issue_entry_t entry_q [DEPTH];
  alu_pkg::issue_entry_t entry_d [DEPTH];
  alu_pkg::issue_entry_t dec_entry;

  logic [XLEN-1:0] dec_op1;
  logic [XLEN-1:0] dec_op2;
  logic [3:0]      dec_alu_op;
  logic [4:0]      dec_rd;
  logic            dec_rd_we;
  logic            dec_illegal;
  logic            out_valid;
  logic            accept;
  logic            retire;

  alu_issue_decode u_decode (
    .instr    (bus.instr),
    .rs1_data (bus.rs1_data),
    .rs2_data (bus.rs2_data),
    .op1      (dec_op1),
    .op2      (dec_op2),
    .alu_op   (dec_alu_op),
    .rd       (dec_rd),
    .rd_we    (dec_rd_we),
    .illegal  (dec_illegal)
  );

  assign dec_entry = '{op1: dec_op1, op2: dec_op2, alu_op: dec_alu_op,
                       rd: dec_rd, rd_we: dec_rd_we, illegal: dec_illegal};

  assign out_valid = (state_q != alu_pkg::ST_EMPTY);
  assign accept    = bus.in_valid && in_ready_q;
  assign retire    = out_valid && bus.out_ready;

  always_comb begin
    state_d = state_q;
    entry_d = entry_q;
    if (flush) begin
      state_d = alu_pkg::ST_EMPTY;
      for (int i = 0; i < DEPTH; i++) begin
        entry_d[i] = alu_pkg::ENTRY_IDLE;
      end
    end else begin
      case (state_q)
        alu_pkg::ST_EMPTY: begin
          if (accept) begin
            entry_d[MAIN] = dec_entry;
            state_d       = alu_pkg::ST_ONE;
          end
        end
        alu_pkg::ST_ONE: begin
          if (accept && retire) begin
            entry_d[MAIN] = dec_entry;
          end else if (accept) begin
            entry_d[SKID] = dec_entry;
            state_d       = alu_pkg::ST_FULL;
          end else if (retire) begin
            state_d = alu_pkg::ST_EMPTY;
          end
        end
        alu_pkg::ST_FULL: begin
          // in_ready is low here, so only a retire can happen.
          if (retire) begin
            entry_d[MAIN] = entry_q[SKID];
            state_d       = alu_pkg::ST_ONE;
          end
        end
        default: state_d = alu_pkg::ST_EMPTY;
      endcase
    end
    // Derived from next state so in_ready never depends on this cycle's out_ready.
    in_ready_d = (state_d != alu_pkg::ST_FULL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= alu_pkg::ST_EMPTY;
      in_ready_q <= 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i] <= alu_pkg::ENTRY_IDLE;
      end
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i] <= entry_d[i];
      end
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid;
  assign bus.op1       = entry_q[MAIN].op1;
  assign bus.op2       = entry_q[MAIN].op2;
  assign bus.alu_op    = entry_q[MAIN].alu_op;
  assign bus.rd        = entry_q[MAIN].rd;
  assign bus.rd_we     = entry_q[MAIN].rd_we;
  assign bus.illegal   = entry_q[MAIN].illegal;

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Issue stage directly upstream of the 32-bit ALU, in the RV32I integer datapath.
- Decodes a 32-bit instruction together with its two register-file read values.
- Selects the ALU operands and computes the 4-bit ALU operation code.
- Holds the result in a registered 2-entry skid buffer with valid/ready handshakes on both sides, so the ALU input is fully registered at full throughput.

Parameters:
- XLEN, 32, datapath width; only 32 supported.
- DEPTH, 2, skid buffer entries; fixed at 2 (main + skid).

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  synchronous, active-high reset
- flush  input  1  synchronous kill of all buffered entries
- in_valid  input  1  upstream presents an instruction
- in_ready  output  1  stage can accept; registered
- instr  input  32  raw RV32I instruction
- rs1_data  input  32  register-file read value for rs1
- rs2_data  input  32  register-file read value for rs2
- out_valid  output  1  issued entry available
- out_ready  input  1  ALU/execute consumes this cycle
- op1  output  32  ALU operand 1
- op2  output  32  ALU operand 2
- alu_op  output  4  ALU operation code
- rd  output  5  destination register index
- rd_we  output  1  result writes back to the register file
- illegal  output  1  instruction not supported by this stage

Behaviour:
- Reset/flush values: all buffer entries empty; out_valid=0; in_ready=1; op1=op2=0; alu_op=ADD; rd=0; rd_we=0; illegal=0.
- Transfers: accept when in_valid & in_ready; retire when out_valid & out_ready.
- Latency: an entry accepted in cycle N appears on the outputs in cycle N+1.
- States:
  - EMPTY: in_ready=1, out_valid=0.
  - ONE: in_ready=1, out_valid=1.
  - FULL: in_ready=0, out_valid=1.
- Transitions:
  - EMPTY --accept--> ONE.
  - ONE --accept & !retire--> FULL.
  - ONE --retire & !accept--> EMPTY.
  - ONE --accept & retire--> ONE; the new entry replaces the output.
  - FULL --retire--> ONE; the skid entry moves to the output.
- Ordering: strict FIFO; there is no combinational path from out_ready to in_ready.
- Priority: rst > flush > handshakes. A flush in the same cycle as an accept drops the incoming instruction.
- ALU op encodings:
  - AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0100, XOR 0101, SRL 1000, SLL 1001, SRA 1010.
- Decode by opcode:
  - R-type 0110011: op1=rs1_data, op2=rs2_data, rd_we=1.
    - funct3 000: ADD, or SUB if instr[30]=1.
    - funct3 001: SLL.
    - funct3 010: SLT.
    - funct3 100: XOR.
    - funct3 101: SRL, or SRA if instr[30]=1.
    - funct3 110: OR.
    - funct3 111: AND.
    - funct3 011: illegal.
    - funct7 other than 0000000 or 0100000: illegal.
  - I-ALU 0010011: op1=rs1_data, op2=sign-extended instr[31:20], rd_we=1; same funct3 map as R-type, with no SUB.
    - Shifts (001/101): op2={27'b0, instr[24:20]}; instr[30] selects SRA for funct3 101.
    - funct3 011: illegal.
  - LOAD 0000011: ADD, op2=I-immediate, rd_we=1.
  - STORE 0100011: ADD, op2=sext({instr[31:25], instr[11:7]}), rd_we=0.
  - BRANCH 1100011: op1=rs1_data, op2=rs2_data, rd_we=0.
    - funct3 000/001: SUB.
    - funct3 100/101: SLT.
    - Other funct3: illegal.
  - Any other opcode: illegal.
- Illegal entries: illegal=1, alu_op=ADD, op1=op2=0, rd_we=0. They still flow through the handshake in order.
- rd field: rd=instr[11:7] always. rd_we is forced to 0 when rd=0.
- Buffered outputs: held stable while out_valid=1 and out_ready=0.

Decomposition:
- Shared package alu_pkg:
  - ALU op code constants (the encodings above).
  - RV32I opcode constants.
  - funct3 constants.
  - XLEN.
- One sub-module: alu_issue_decode, purely combinational, mapping instr/rs1/rs2 to op1, op2, alu_op, rd, rd_we, illegal.
- The top level holds the skid-buffer FSM and the entry registers.

Test Plan:
- Reset, then ADD x3,x1,x2 (0x002081B3), rs1=5, rs2=7, out_ready=1 -> next cycle out_valid=1, op1=5, op2=7, alu_op=0010, rd=3, rd_we=1.
- SRAI x5,x6,4 (0x40435293), rs1=0xF0000000 -> alu_op=1010, op2=4, rd_we=1.
- SW (0x0020A423), rs1=0x100 -> alu_op=0010, op2=8, rd_we=0. BLT (0x0020C463) -> alu_op=0100, op2=rs2_data.
- out_ready=0, issue 3 back-to-back instructions -> 2 accepted, in_ready=0 from the cycle after the 2nd accept. Then out_ready=1 -> outputs drain in order, third is accepted, no loss or duplication.
- FULL state, assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, and the incoming entry is dropped.
- SLTU (0x0020B1B3) and opcode 0x7F -> illegal=1, alu_op=0010, op1=op2=0, rd_we=0, and order is preserved.
